seven_seg_scan_ctrl: RTL

Time-multiplexed scan controller for the Nexys A7 eight-digit seven-segment display. It holds a frame of eight 4-bit digit codes and presents one digit at a time on a shared `bcd` bus, which feeds the team's single combinational seven-segment decoder. It drives the matching active-low anode, inserts a blanking gap between digits to prevent ghosting, and applies new frames from the game logic only at frame boundaries so the display never tears.

---
 rtl/seg_scan_pkg.sv | 23 ++
 rtl/seg_scan_frame_buf.sv | 68 ++++++
 rtl/seven_seg_scan_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and defaults for the seven-segment scan controller.
package seg_scan_pkg;

  typedef enum logic {
    StBlank = 1'b0,
    StShow  = 1'b1
  } scan_state_e;

  localparam int unsigned DefNumDigits   = 8;
  localparam int unsigned DefSlotCycles  = 100000;
  localparam int unsigned DefBlankCycles = 1000;

  localparam int unsigned CodeW     = 4;
  // One frame record per digit: code, enable, decimal point.
  localparam int unsigned FrameRecW = CodeW + 2;

  typedef struct packed {
    logic [CodeW-1:0] code;
    logic             en;
    logic             dp;
  } digit_rec_t;

endpackage

// File: rtl/seg_scan_frame_buf.sv
// Shadow/active frame double buffer. Loads land in the shadow frame and are
// promoted to the active frame only at the frame wrap, so a scan never tears.
module seg_scan_frame_buf
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = DefNumDigits
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            load_i,
  input  logic                            wrap_i,
  input  logic [CodeW*NUM_DIGITS-1:0]     digits_i,
  input  logic [NUM_DIGITS-1:0]           en_i,
  input  logic [NUM_DIGITS-1:0]           dp_i,
  output logic [FrameRecW*NUM_DIGITS-1:0] active_o,
  output logic                            pending_o
);

  digit_rec_t [NUM_DIGITS-1:0] in_frame;
  digit_rec_t [NUM_DIGITS-1:0] shadow_q, shadow_d;
  digit_rec_t [NUM_DIGITS-1:0] active_q, active_d;
  logic                        pending_q, pending_d;

  // Repack the three input buses into per-digit records.
  always_comb begin
    in_frame = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      in_frame[i].code = digits_i[CodeW*i +: CodeW];
      in_frame[i].en   = en_i[i];
      in_frame[i].dp   = dp_i[i];
    end
  end

  // Shadow capture, pending tracking and wrap-time promotion (with bypass
  // when a load coincides with the wrap).
  always_comb begin
    shadow_d  = load_i ? in_frame : shadow_q;
    pending_d = pending_q;
    active_d  = active_q;
    if (wrap_i) begin
      pending_d = 1'b0;
      if (load_i) begin
        active_d = in_frame;
      end else if (pending_q) begin
        active_d = shadow_q;
      end
    end else if (load_i) begin
      pending_d = 1'b1;
    end
  end

  // Frame registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  assign active_o  = active_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for an eight-digit seven-segment display.
// Each slot starts with a blanking gap (all anodes off) before the digit is
// shown. Optional leading-zero suppression: SEG_SCAN_LEADING_ZERO_BLANK_EN.
module seven_seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = DefNumDigits,
  parameter int unsigned SLOT_CYCLES  = DefSlotCycles,
  parameter int unsigned BLANK_CYCLES = DefBlankCycles
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   digit_en_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic [3:0]              bcd,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp_n,
  output logic                    frame_done
);

  localparam int unsigned CntW = $clog2(SLOT_CYCLES);
  localparam int unsigned IdxW = $clog2(NUM_DIGITS);
  localparam logic [CntW-1:0] CntBlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] CntSlotLast  = CntW'(SLOT_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast      = IdxW'(NUM_DIGITS - 1);

  scan_state_e                 state_q, state_d;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic [IdxW-1:0]             idx_q, idx_d;
  logic                        slot_end, wrap;
  digit_rec_t [NUM_DIGITS-1:0] act;
  digit_rec_t                  cur;
  logic                        lz_blank;

  logic [3:0]            bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  dp_n_q, dp_n_d;
  logic                  frame_done_q;

  seg_scan_frame_buf #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_frame_buf (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .load_i   (load),
    .wrap_i   (wrap),
    .digits_i (digits_in),
    .en_i     (digit_en_in),
    .dp_i     (dp_in),
    .active_o (act),
    .pending_o()
  );

  assign slot_end = (state_q == StShow) && (cnt_q == CntSlotLast);
  assign wrap     = slot_end && (idx_q == IdxLast);
  assign cur      = act[idx_q];

  // State, slot counter and digit index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBlank;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next state: blank gap then show; slot end advances the digit index.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    unique case (state_q)
      StBlank: if (cnt_q == CntBlankLast) state_d = StShow;
      StShow: begin
        if (slot_end) begin
          state_d = StBlank;
          cnt_d   = '0;
          idx_d   = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
        end
      end
      default: state_d = StBlank;
    endcase
  end

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  // Suppress a zero digit when no higher digit carries a visible nonzero code.
  always_comb begin
    lz_blank = (idx_q != '0) && (cur.code == '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i > int'(idx_q) && act[i].en && (act[i].code != '0)) lz_blank = 1'b0;
    end
  end
`else
  assign lz_blank = 1'b0;
`endif

  // Output decode; bcd leads the anode so the decoder settles during the gap.
  always_comb begin
    bcd_d  = cur.code;
    an_d   = '1;
    dp_n_d = 1'b1;
    if ((state_q == StShow) && cur.en && !lz_blank) begin
      an_d[idx_q] = 1'b0;
      dp_n_d      = ~cur.dp;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q        <= '0;
      an_q         <= '1;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      bcd_q        <= bcd_d;
      an_q         <= an_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= wrap;
    end
  end

  assign bcd        = bcd_q;
  assign an         = an_q;
  assign dp_n       = dp_n_q;
  assign frame_done = frame_done_q;

endmodule
